// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: Core (master 0) and loader/debug (master 1) share
// one Memory port. Round-robin on contention, single outstanding transaction,
// per-transaction timeout that completes the owner with an error flag.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_rd_i,
  input  logic                  m0_wr_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m1_rd_i,
  input  logic                  m1_wr_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  mem_rd_o,
  output logic                  mem_wr_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_ack_i,
  output logic [1:0]            grant_o,
  output logic                  busy_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t          state;
  logic            last_grant;  // 0 = master 0 served last, 1 = master 1
  logic            owner;       // master holding the memory port
  logic [CW-1:0]   count;

  logic            req0;
  logic            req1;
  logic            pick1;
  logic            win_wr;
  logic            win_rd;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;

  // Winner selection: a lone requester wins, contention goes to the master
  // that was not served last. Write beats read within one master.
  always_comb begin
    req0     = m0_rd_i | m0_wr_i;
    req1     = m1_rd_i | m1_wr_i;
    pick1    = req1 & (~req0 | ~last_grant);
    win_wr   = pick1 ? m1_wr_i   : m0_wr_i;
    win_rd   = (pick1 ? m1_rd_i  : m0_rd_i) & ~win_wr;
    win_addr = pick1 ? m1_addr_i : m0_addr_i;
    win_data = pick1 ? m1_data_i : m0_data_i;
  end

  // Arbitration FSM with registered memory strobes and master responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      count      <= '0;
      mem_rd_o   <= 1'b0;
      mem_wr_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      grant_o    <= '0;
      busy_o     <= 1'b0;
      m0_ack_o   <= 1'b0;
      m0_err_o   <= 1'b0;
      m0_data_o  <= '0;
      m1_ack_o   <= 1'b0;
      m1_err_o   <= 1'b0;
      m1_data_o  <= '0;
    end else begin
      m0_ack_o <= 1'b0;
      m0_err_o <= 1'b0;
      m1_ack_o <= 1'b0;
      m1_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            owner      <= pick1;
            last_grant <= pick1;
            grant_o    <= pick1 ? 2'b10 : 2'b01;
            mem_wr_o   <= win_wr;
            mem_rd_o   <= win_rd;
            mem_addr_o <= win_addr;
            mem_data_o <= win_data;
            count      <= '0;
            busy_o     <= 1'b1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            // Ack takes priority over a coincident timeout.
            if (owner) begin
              m1_ack_o <= 1'b1;
              if (mem_rd_o) m1_data_o <= mem_data_i;
            end else begin
              m0_ack_o <= 1'b1;
              if (mem_rd_o) m0_data_o <= mem_data_i;
            end
            mem_rd_o <= 1'b0;
            mem_wr_o <= 1'b0;
            grant_o  <= '0;
            busy_o   <= 1'b0;
            state    <= IDLE;
          end else if (count == LAST_COUNT) begin
            if (owner) begin
              m1_ack_o <= 1'b1;
              m1_err_o <= 1'b1;
            end else begin
              m0_ack_o <= 1'b1;
              m0_err_o <= 1'b1;
            end
            mem_rd_o <= 1'b0;
            mem_wr_o <= 1'b0;
            grant_o  <= '0;
            busy_o   <= 1'b0;
            state    <= IDLE;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
